arb_mux: RTL and testbench
==========================

Name: arb_mux

Overview:
- Parametrised, registered N-way select block; successor to the combinational 4-way operand mux.
- Merges NUM_CH valid/ready source channels onto one registered output channel.
- Source choice per transfer comes from one of three places: a forced select (legacy mux behaviour), fixed priority, or round-robin arbitration.
- Sits between multi-cycle datapath producers (ALU result, memory data, immediate, PC) and shared consumers (register-file write port, memory address bus).

Parameters:
- NUM_CH, 4: number of source channels, 2..16.
- WIDTH, 32: data width per channel.
- RR_EN, 1: 1 = round-robin arbitration; 0 = fixed priority, lowest index wins.
- SEL_W, $clog2(NUM_CH): width of the select and grant index; derived, never overridden.

Ports:
- CLK, input, 1: rising-edge clock.
- Reset, input, 1: synchronous, active-high reset.
- In_Valid, input, NUM_CH: per-channel data valid.
- In_Ready, output, NUM_CH: per-channel accept, combinational.
- In_Data, input, NUM_CH*WIDTH: packed data; channel i occupies bits [i*WIDTH +: WIDTH].
- Force_En, input, 1: when high, the source is Force_Sel and arbitration is bypassed.
- Force_Sel, input, SEL_W: forced channel index.
- Out_Valid, output, 1: registered output valid.
- Out_Ready, input, 1: consumer accept.
- Out_Data, output, WIDTH: registered output data.
- Out_Sel, output, SEL_W: channel index that produced Out_Data.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous, active-high, named Reset.
- Reset values: Out_Valid=0, Out_Data=0, Out_Sel=0, rr_ptr=0.
- Reset dominates every other event in the same cycle. Reset mid-transfer discards the held output word; In_Ready is all zeros while Reset is high.
- Output stage is a single register:
  - load = ~Out_Valid | Out_Ready.
  - On a cycle with load=1 and a granted channel g, at the edge: Out_Data<=In_Data[g], Out_Sel<=g, Out_Valid<=1.
  - On a cycle with load=1 and no grant: Out_Valid<=0.
  - On a cycle with load=0: output registers hold.
- Latency is 1 cycle from source handshake to Out_Valid. Throughput is 1 word per cycle when Out_Ready is held high.
- Grant selection:
  - Force_En=1: g=Force_Sel if In_Valid[Force_Sel]=1, otherwise no grant. Other channels are never granted.
  - Force_En=0 and RR_EN=0: g is the lowest index with In_Valid set.
  - Force_En=0 and RR_EN=1: g is the first valid index searching upward from rr_ptr, wrapping from NUM_CH-1 to 0.
- Handshakes:
  - In_Ready[i] = load & grant_valid & (g==i) & ~Reset. At most one bit of In_Ready is high per cycle.
  - A source transfer completes on In_Valid[i] & In_Ready[i].
  - A source must hold In_Valid and In_Data until it sees In_Ready.
- Round-robin pointer: after a completed source transfer from channel g, rr_ptr<=(g==NUM_CH-1)?0:g+1. The pointer updates only on transfers, including forced ones.
- Out-of-range Force_Sel (>=NUM_CH, possible when NUM_CH is not a power of 2) produces no grant. No transfer occurs and Out_Valid falls to 0 once drained.
- Simultaneous drain and refill (Out_Valid=1, Out_Ready=1, a grant present): the new word loads in the same cycle with no bubble.
- Out_Data and Out_Sel are stable while Out_Valid=1 and Out_Ready=0.

Decomposition:
- Package mux_pkg holds:
  - Select-width helper function.
  - Constants MODE_FIXED=0 and MODE_RR=1.
  - Named channel indices for datapath use: CH_ALU=0, CH_MEM=1, CH_IMM=2, CH_PC=3.
- One sub-module: rr_pick. It is purely combinational: inputs are the request vector and start pointer; outputs are grant index and grant_valid. It is reused for fixed priority by tying the start pointer to 0.

Test Plan:
- Reset: drive Reset=1 with all In_Valid set -> Out_Valid=0, Out_Data=0, In_Ready=0. Deassert Reset -> channel 0 is granted on the next cycle.
- Round-robin fairness:
  - Setup: NUM_CH=4, RR_EN=1, all valid, Out_Ready=1, In_Data[i]=32'hA0+i.
  - Required: Out_Sel sequence 0,1,2,3,0. Out_Data sequence A0,A1,A2,A3,A0. One word per cycle, no bubbles.
- Fixed priority: RR_EN=0 with channels 1 and 3 valid -> channel 1 wins repeatedly and channel 3 starves. Drop channel 1 -> Out_Sel=3 on the next load.
- Forced select:
  - Force_En=1, Force_Sel=2, all valid, In_Data[2]=32'hDEADBEEF -> Out_Data=DEADBEEF, Out_Sel=2. In_Ready[0,1,3] stay 0.
  - Force_Sel=2 with In_Valid[2]=0 -> no transfer.
- Backpressure: Out_Ready=0 for 3 cycles while Out_Valid=1 -> Out_Data holds, In_Ready=0, rr_ptr is unchanged. Out_Ready=1 -> the next word loads in the same cycle.
- Reset mid-operation: assert Reset while Out_Valid=1 and Out_Ready=0 -> the next cycle shows Out_Valid=0 and rr_ptr=0, and the held word is not delivered.

Source files
------------

// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
//   Shared constants and helpers for the arb_mux select block and its users.
//
//   Contents:
//     sel_width()        width of a channel index for a given channel count
//     MODE_FIXED/MODE_RR values for the arb_mux RR_EN parameter
//     CH_ALU..CH_PC      channel numbering used by the datapath producers
// -----------------------------------------------------------------------------
package mux_pkg;

    // Arbitration modes (RR_EN parameter values)
    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Datapath source channel assignment
    localparam int CH_ALU = 0;
    localparam int CH_MEM = 1;
    localparam int CH_IMM = 2;
    localparam int CH_PC  = 3;

    // Index width for n channels; never narrower than one bit so that a
    // two-channel instance still has a usable select port.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational first-set picker. Starting at start_i and searching upward
//   (wrapping from NUM_CH-1 back to 0), returns the first index whose request
//   bit is set. Tying start_i to zero turns it into a lowest-index-wins
//   priority encoder.
//
//   Ports:
//     req_i         [NUM_CH-1:0] request vector
//     start_i       [SEL_W-1:0]  first index to consider (must be < NUM_CH)
//     grant_o       [SEL_W-1:0]  winning index (0 when nothing requests)
//     grant_valid_o              at least one request was set
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
) (
    input  logic [NUM_CH-1:0] req_i,
    input  logic [SEL_W-1:0]  start_i,
    output logic [SEL_W-1:0]  grant_o,
    output logic              grant_valid_o
);

    int pos;

    // Walk the offsets from farthest to nearest so that the nearest set
    // request is the last one written and therefore wins.
    always_comb begin
        grant_o       = '0;
        grant_valid_o = 1'b0;
        pos           = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            pos = int'(start_i) + k;
            if (pos >= NUM_CH) begin
                pos = pos - NUM_CH;
            end
            if (req_i[pos[SEL_W-1:0]]) begin
                grant_o       = pos[SEL_W-1:0];
                grant_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arb_mux.sv
// -----------------------------------------------------------------------------
// arb_mux
//   Registered NUM_CH-way valid/ready merge. Each transfer's source is either
//   a forced channel (Force_En/Force_Sel, the old operand-mux behaviour), the
//   lowest valid channel (RR_EN = MODE_FIXED) or the next valid channel after
//   the last one served (RR_EN = MODE_RR). The output is a single register
//   stage that refills in the same cycle it drains, so a steadily ready
//   consumer sees one word per clock.
//
//   Ports:
//     CLK        rising-edge clock
//     Reset      synchronous active-high reset, dominates everything
//     In_Valid   [NUM_CH]        per-source valid
//     In_Ready   [NUM_CH]        per-source accept (combinational, one-hot or 0)
//     In_Data    [NUM_CH*WIDTH]  packed source data, channel i at [i*WIDTH +: WIDTH]
//     Force_En   bypass arbitration and take Force_Sel
//     Force_Sel  [SEL_W]         forced source index
//     Out_Valid  registered output valid
//     Out_Ready  consumer accept
//     Out_Data   [WIDTH]         registered output data
//     Out_Sel    [SEL_W]         source index of Out_Data
// -----------------------------------------------------------------------------
module arb_mux
    import mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int WIDTH  = 32,
    parameter  int RR_EN  = MODE_RR,
    localparam int SEL_W  = sel_width(NUM_CH)
) (
    input  logic                    CLK,
    input  logic                    Reset,
    input  logic [NUM_CH-1:0]       In_Valid,
    output logic [NUM_CH-1:0]       In_Ready,
    input  logic [NUM_CH*WIDTH-1:0] In_Data,
    input  logic                    Force_En,
    input  logic [SEL_W-1:0]        Force_Sel,
    output logic                    Out_Valid,
    input  logic                    Out_Ready,
    output logic [WIDTH-1:0]        Out_Data,
    output logic [SEL_W-1:0]        Out_Sel
);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [SEL_W-1:0] rr_ptr_q,    rr_ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_sel_q,   out_sel_d;

    // -------------------------------------------------------------------------
    // Grant selection
    // -------------------------------------------------------------------------
    logic [SEL_W-1:0] arb_start;
    logic [SEL_W-1:0] arb_grant;
    logic             arb_valid;
    logic             force_valid;
    logic [SEL_W-1:0] grant;
    logic             grant_valid;
    logic [WIDTH-1:0] grant_data;
    logic             load;
    logic             xfer;

    // Fixed priority is the round-robin search anchored at channel 0.
    assign arb_start = (RR_EN == MODE_RR) ? rr_ptr_q : '0;

    rr_pick #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_rr_pick (
        .req_i         (In_Valid),
        .start_i       (arb_start),
        .grant_o       (arb_grant),
        .grant_valid_o (arb_valid)
    );

    // Compare against every legal index rather than indexing In_Valid
    // directly: an out-of-range Force_Sel then simply matches nothing and
    // yields no grant.
    always_comb begin
        force_valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (Force_Sel == SEL_W'(i)) begin
                force_valid = In_Valid[i];
            end
        end
    end

    always_comb begin
        if (Force_En) begin
            grant       = Force_Sel;
            grant_valid = force_valid;
        end else begin
            grant       = arb_grant;
            grant_valid = arb_valid;
        end
    end

    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant == SEL_W'(i)) begin
                grant_data = In_Data[i*WIDTH +: WIDTH];
            end
        end
    end

    // The output register can take a word when it is empty or being drained
    // this cycle; that is what gives back-to-back transfers with no bubble.
    assign load = ~out_valid_q | Out_Ready;
    assign xfer = load & grant_valid & ~Reset;

    always_comb begin
        In_Ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            In_Ready[i] = xfer & (grant == SEL_W'(i));
        end
    end

    // -------------------------------------------------------------------------
    // Next state
    // -------------------------------------------------------------------------
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        rr_ptr_d    = rr_ptr_q;

        if (load) begin
            out_valid_d = grant_valid;
            if (grant_valid) begin
                out_data_d = grant_data;
                out_sel_d  = grant;
            end
        end

        // Forced transfers advance the pointer too, so arbitration resumes
        // after whichever channel was served last.
        if (xfer) begin
            if (grant == SEL_W'(NUM_CH - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant + SEL_W'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (Reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign Out_Valid = out_valid_q;
    assign Out_Data  = out_data_q;
    assign Out_Sel   = out_sel_q;

`ifndef SYNTHESIS
    // Only one source may be accepted per cycle.
    a_ready_onehot : assert property (@(posedge CLK) $onehot0(In_Ready));

    // A stalled output word must not change underneath the consumer.
    a_hold_stable : assert property (
        @(posedge CLK) disable iff (Reset)
        (Out_Valid && !Out_Ready) |=> (Out_Valid && $stable(Out_Data) && $stable(Out_Sel))
    );
`endif

endmodule

// File: tb/tb_arb_mux.sv
// -----------------------------------------------------------------------------
// tb_arb_mux
//   Three arb_mux instances share one set of sources:
//     u0: NUM_CH=4, round-robin     u1: NUM_CH=4, fixed priority
//     u2: NUM_CH=3, round-robin (Force_Sel=3 is out of range there)
//   A behavioural model tracks each instance's output word and pointer and
//   predicts In_Ready and the registered outputs every cycle. Directed
//   scenarios are followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_arb_mux;

    localparam int W = 32;

    logic           CLK = 1'b0;
    logic           Reset;
    logic [3:0]     vld;
    logic [W-1:0]   din [4];
    logic [4*W-1:0] in_data;
    logic           force_en;
    logic [1:0]     force_sel;
    logic           ordy;

    always #5 CLK = ~CLK;

    always_comb begin
        in_data = '0;
        for (int i = 0; i < 4; i++) in_data[i*W +: W] = din[i];
    end

    logic [3:0]   rdy0, rdy1;
    logic [2:0]   rdy2;
    logic         ov0, ov1, ov2;
    logic [W-1:0] od0, od1, od2;
    logic [1:0]   os0, os1, os2;

    arb_mux #(.NUM_CH(4), .WIDTH(W), .RR_EN(1)) u0 (
        .CLK(CLK), .Reset(Reset), .In_Valid(vld), .In_Ready(rdy0), .In_Data(in_data),
        .Force_En(force_en), .Force_Sel(force_sel), .Out_Valid(ov0), .Out_Ready(ordy),
        .Out_Data(od0), .Out_Sel(os0)
    );

    arb_mux #(.NUM_CH(4), .WIDTH(W), .RR_EN(0)) u1 (
        .CLK(CLK), .Reset(Reset), .In_Valid(vld), .In_Ready(rdy1), .In_Data(in_data),
        .Force_En(force_en), .Force_Sel(force_sel), .Out_Valid(ov1), .Out_Ready(ordy),
        .Out_Data(od1), .Out_Sel(os1)
    );

    arb_mux #(.NUM_CH(3), .WIDTH(W), .RR_EN(1)) u2 (
        .CLK(CLK), .Reset(Reset), .In_Valid(vld[2:0]), .In_Ready(rdy2), .In_Data(in_data[3*W-1:0]),
        .Force_En(force_en), .Force_Sel(force_sel), .Out_Valid(ov2), .Out_Ready(ordy),
        .Out_Data(od2), .Out_Sel(os2)
    );

    logic [3:0]   a_rdy [3];
    logic         a_ov  [3];
    logic [W-1:0] a_od  [3];
    logic [1:0]   a_os  [3];

    assign a_rdy[0] = rdy0;
    assign a_rdy[1] = rdy1;
    assign a_rdy[2] = {1'b0, rdy2};
    assign a_ov[0]  = ov0;
    assign a_ov[1]  = ov1;
    assign a_ov[2]  = ov2;
    assign a_od[0]  = od0;
    assign a_od[1]  = od1;
    assign a_od[2]  = od2;
    assign a_os[0]  = os0;
    assign a_os[1]  = os1;
    assign a_os[2]  = os2;

    // Reference model state, one entry per instance
    int           m_n   [3] = '{4, 4, 3};
    bit           m_rr  [3] = '{1'b1, 1'b0, 1'b1};
    bit           m_ov  [3];
    logic [W-1:0] m_od  [3];
    int           m_os  [3];
    int           m_ptr [3];
    bit           m_gv  [3];
    int           m_g   [3];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Which channel the rules grant this cycle for instance k
    task automatic model_pick(input int k);
        int start;
        int c;
        m_gv[k] = 1'b0;
        m_g[k]  = 0;
        if (force_en) begin
            if (int'(force_sel) < m_n[k] && vld[force_sel]) begin
                m_gv[k] = 1'b1;
                m_g[k]  = int'(force_sel);
            end
        end else begin
            start = m_rr[k] ? m_ptr[k] : 0;
            for (int j = 0; j < m_n[k]; j++) begin
                c = (start + j) % m_n[k];
                if (!m_gv[k] && vld[c]) begin
                    m_gv[k] = 1'b1;
                    m_g[k]  = c;
                end
            end
        end
    endtask

    // One clock: check In_Ready mid-cycle, advance the model at the edge,
    // check the registered outputs just after it.
    task automatic tick();
        logic [3:0] exp_rdy;
        bit         ld;
        @(negedge CLK);
        for (int k = 0; k < 3; k++) begin
            model_pick(k);
            ld      = !m_ov[k] || ordy;
            exp_rdy = '0;
            if (!Reset && ld && m_gv[k]) exp_rdy[m_g[k]] = 1'b1;
            chk($sformatf("u%0d_in_ready", k), 64'(a_rdy[k]), 64'(exp_rdy));
        end
        @(posedge CLK);
        for (int k = 0; k < 3; k++) begin
            ld = !m_ov[k] || ordy;
            if (Reset) begin
                m_ov[k]  = 1'b0;
                m_od[k]  = '0;
                m_os[k]  = 0;
                m_ptr[k] = 0;
            end else if (ld) begin
                m_ov[k] = m_gv[k];
                if (m_gv[k]) begin
                    m_od[k]  = din[m_g[k]];
                    m_os[k]  = m_g[k];
                    m_ptr[k] = (m_g[k] + 1) % m_n[k];
                end
            end
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d_out_valid", k), 64'(a_ov[k]), 64'(m_ov[k]));
            chk($sformatf("u%0d_out_data", k), 64'(a_od[k]), 64'(m_od[k]));
            chk($sformatf("u%0d_out_sel", k), 64'(a_os[k]), 64'(m_os[k]));
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_ov[k] = 1'b0; m_od[k] = '0; m_os[k] = 0; m_ptr[k] = 0;
        end
        Reset     = 1'b1;
        vld       = 4'hF;
        force_en  = 1'b0;
        force_sel = 2'd0;
        ordy      = 1'b1;
        for (int i = 0; i < 4; i++) din[i] = 32'hA0 + i;

        // Reset with every source valid
        tick();
        tick();
        chk("rst_out_valid", 64'(ov0), 64'd0);
        chk("rst_out_data", 64'(od0), 64'd0);
        chk("rst_in_ready", 64'(rdy0), 64'd0);

        // Round-robin fairness, channel 0 first after reset
        Reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_valid", 64'(ov0), 64'd1);
            chk("rr_sel", 64'(os0), 64'(i % 4));
            chk("rr_data", 64'(od0), 64'(32'hA0 + (i % 4)));
            chk("fp_all_valid_sel", 64'(os1), 64'd0);
        end

        // Fixed priority: 1 beats 3 until 1 drops
        vld = 4'b1010;
        repeat (3) begin
            tick();
            chk("fp_win_ch1", 64'(os1), 64'd1);
        end
        vld = 4'b1000;
        tick();
        chk("fp_then_ch3", 64'(os1), 64'd3);

        // Forced select
        force_en  = 1'b1;
        force_sel = 2'd2;
        vld       = 4'hF;
        din[2]    = 32'hDEADBEEF;
        tick();
        chk("force_data", 64'(od0), 64'hDEADBEEF);
        chk("force_sel", 64'(os0), 64'd2);
        chk("force_ready", 64'(rdy0), 64'b0100);
        vld = 4'b1011;
        tick();
        chk("force_invalid_out", 64'(ov0), 64'd0);
        chk("force_invalid_rdy", 64'(rdy0), 64'd0);
        force_sel = 2'd3;
        vld       = 4'hF;
        tick();
        chk("force_oor_valid", 64'(ov2), 64'd0);
        chk("force3_sel", 64'(os0), 64'd3);
        tick();
        chk("force_oor_drained", 64'(ov2), 64'd0);

        // Backpressure: u0 pointer is 0 here, so channel 0 loads then stalls
        force_en = 1'b0;
        tick();
        chk("bp_load_sel", 64'(os0), 64'd0);
        ordy = 1'b0;
        repeat (3) begin
            tick();
            chk("bp_hold_sel", 64'(os0), 64'd0);
            chk("bp_hold_data", 64'(od0), 64'hA0);
            chk("bp_ready_low", 64'(rdy0), 64'd0);
        end
        ordy = 1'b1;
        tick();
        chk("bp_resume_valid", 64'(ov0), 64'd1);
        chk("bp_resume_sel", 64'(os0), 64'd1);
        chk("bp_resume_data", 64'(od0), 64'hA1);

        // Reset while a word is held
        ordy = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        chk("midrst_valid", 64'(ov0), 64'd0);
        Reset = 1'b0;
        ordy  = 1'b1;
        tick();
        chk("midrst_restart_sel", 64'(os0), 64'd0);
        chk("midrst_restart_data", 64'(od0), 64'hA0);

        // Randomized traffic
        repeat (600) begin
            Reset     = ($urandom_range(0, 49) == 0);
            vld       = 4'($urandom);
            force_en  = ($urandom_range(0, 3) == 0);
            force_sel = 2'($urandom);
            ordy      = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) din[i] = $urandom;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
